// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, widths and state type for the UART command controller.
package sys_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_ALU_DATA_WIDTH = 16;
    localparam int unsigned DEF_ALU_FUNC_WIDTH = 4;
    localparam int unsigned DEF_ADDR_WIDTH     = 4;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StOpA,
        StOpB,
        StFun,
        StAluWait,
        StPushLo,
        StPushHi,
        StPushRd
    } ctrl_state_e;

    // First state of a command; StIdle marks an unknown opcode.
    function automatic ctrl_state_e cmd_next_state(input logic [7:0] opcode);
        case (opcode)
            CMD_WR:      return StWrAddr;
            CMD_RD:      return StRdAddr;
            CMD_ALU_OP:  return StOpA;
            CMD_ALU_NOP: return StFun;
            default:     return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Data and handshake bundle between the command controller and the UART RX,
// register file, ALU and TX FIFO.
interface sys_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH     = sys_ctrl_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ALU_DATA_WIDTH = sys_ctrl_pkg::DEF_ALU_DATA_WIDTH,
    parameter int unsigned ALU_FUNC_WIDTH = sys_ctrl_pkg::DEF_ALU_FUNC_WIDTH,
    parameter int unsigned ADDR_WIDTH     = sys_ctrl_pkg::DEF_ADDR_WIDTH
);
    import sys_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0]     rx_p_data;
    logic                      rx_d_valid;
    logic [ADDR_WIDTH-1:0]     rf_addr;
    logic                      rf_wr_en;
    logic                      rf_rd_en;
    logic [DATA_WIDTH-1:0]     rf_wr_data;
    logic [DATA_WIDTH-1:0]     rf_rd_data;
    logic                      rf_rd_valid;
    logic                      alu_en;
    logic [ALU_FUNC_WIDTH-1:0] alu_fun;
    logic [ALU_DATA_WIDTH-1:0] alu_out;
    logic                      alu_out_valid;
    logic                      alu_clk_en;
    logic [DATA_WIDTH-1:0]     fifo_wr_data;
    logic                      fifo_wr_inc;
    logic                      fifo_full;
    logic                      busy;
    logic                      cmd_err;

    modport master (
        input  rx_p_data,
        input  rx_d_valid,
        output rf_addr,
        output rf_wr_en,
        output rf_rd_en,
        output rf_wr_data,
        input  rf_rd_data,
        input  rf_rd_valid,
        output alu_en,
        output alu_fun,
        input  alu_out,
        input  alu_out_valid,
        output alu_clk_en,
        output fifo_wr_data,
        output fifo_wr_inc,
        input  fifo_full,
        output busy,
        output cmd_err
    );

    modport slave (
        output rx_p_data,
        output rx_d_valid,
        input  rf_addr,
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_wr_data,
        output rf_rd_data,
        output rf_rd_valid,
        input  alu_en,
        input  alu_fun,
        output alu_out,
        output alu_out_valid,
        input  alu_clk_en,
        input  fifo_wr_data,
        input  fifo_wr_inc,
        output fifo_full,
        input  busy,
        input  cmd_err
    );

endinterface

// File: rtl/sys_ctrl_tx_push.sv
// One-byte push into the TX FIFO with full-flag back-pressure.
// o_done pulses the cycle after the push strobe, so consecutive pushes never abut.
module sys_ctrl_tx_push
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_wr_inc,
    output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
    output logic                  o_done
);

    logic [DATA_WIDTH-1:0] r_byte;
    logic                  r_pending;
    logic                  r_inc;
    logic                  r_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_byte    <= '0;
            r_pending <= 1'b0;
            r_inc     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_inc  <= 1'b0;
            r_done <= r_inc;
            if (i_start) begin
                r_byte    <= i_byte;
                r_pending <= 1'b1;
            end else if (r_pending && !i_fifo_full) begin
                r_inc     <= 1'b1;
                r_pending <= 1'b0;
            end
        end
    end

    assign o_fifo_wr_inc  = r_inc;
    assign o_fifo_wr_data = r_byte;
    assign o_done         = r_done;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART byte frames into register-file writes/reads and
// ALU operations, and returns read/ALU results through the TX FIFO.
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ALU_DATA_WIDTH = DEF_ALU_DATA_WIDTH,
    parameter int unsigned ALU_FUNC_WIDTH = DEF_ALU_FUNC_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input logic            CLK,
    input logic            RST,
    sys_cmd_ctrl_if.master bus
);

    ctrl_state_e               r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wr_data;
    logic                      r_wr_en;
    logic                      r_rd_en;
    logic                      r_alu_en;
    logic [ALU_FUNC_WIDTH-1:0] r_alu_fun;
    logic                      r_alu_clk_en;
    logic [DATA_WIDTH-1:0]     r_alu_hi;
    logic                      r_cmd_err;
    logic                      r_push_start;
    logic [DATA_WIDTH-1:0]     r_push_byte;

    logic [7:0]            w_opcode;
    ctrl_state_e           w_cmd_state;
    logic                  w_push_done;
    logic                  w_fifo_wr_inc;
    logic [DATA_WIDTH-1:0] w_fifo_wr_data;

    assign w_opcode    = bus.rx_p_data[7:0];
    assign w_cmd_state = cmd_next_state(w_opcode);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_alu_en     <= 1'b0;
            r_alu_fun    <= '0;
            r_alu_clk_en <= 1'b0;
            r_alu_hi     <= '0;
            r_cmd_err    <= 1'b0;
            r_push_start <= 1'b0;
            r_push_byte  <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_alu_en     <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_push_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.rx_d_valid) begin
                        r_state      <= w_cmd_state;
                        r_cmd_err    <= (w_cmd_state == StIdle);
                        r_alu_clk_en <= (w_cmd_state == StFun);
                    end
                end
                StWrAddr: begin
                    if (bus.rx_d_valid) begin
                        r_addr  <= bus.rx_p_data[ADDR_WIDTH-1:0];
                        r_state <= StWrData;
                    end
                end
                StWrData: begin
                    if (bus.rx_d_valid) begin
                        r_wr_data <= bus.rx_p_data;
                        r_wr_en   <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                StRdAddr: begin
                    if (bus.rx_d_valid) begin
                        r_addr  <= bus.rx_p_data[ADDR_WIDTH-1:0];
                        r_rd_en <= 1'b1;
                        r_state <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (bus.rf_rd_valid) begin
                        r_push_byte  <= bus.rf_rd_data;
                        r_push_start <= 1'b1;
                        r_state      <= StPushRd;
                    end
                end
                StOpA: begin
                    if (bus.rx_d_valid) begin
                        r_addr    <= ADDR_WIDTH'(OPA_ADDR);
                        r_wr_data <= bus.rx_p_data;
                        r_wr_en   <= 1'b1;
                        r_state   <= StOpB;
                    end
                end
                StOpB: begin
                    if (bus.rx_d_valid) begin
                        r_addr       <= ADDR_WIDTH'(OPB_ADDR);
                        r_wr_data    <= bus.rx_p_data;
                        r_wr_en      <= 1'b1;
                        r_alu_clk_en <= 1'b1;
                        r_state      <= StFun;
                    end
                end
                StFun: begin
                    if (bus.rx_d_valid) begin
                        r_alu_fun <= bus.rx_p_data[ALU_FUNC_WIDTH-1:0];
                        r_alu_en  <= 1'b1;
                        r_state   <= StAluWait;
                    end
                end
                StAluWait: begin
                    // ALU clock stays enabled through the result cycle only.
                    if (bus.alu_out_valid) begin
                        r_alu_hi     <= bus.alu_out[ALU_DATA_WIDTH-1:DATA_WIDTH];
                        r_push_byte  <= bus.alu_out[DATA_WIDTH-1:0];
                        r_push_start <= 1'b1;
                        r_alu_clk_en <= 1'b0;
                        r_state      <= StPushLo;
                    end
                end
                StPushLo: begin
                    if (w_push_done) begin
                        r_push_byte  <= r_alu_hi;
                        r_push_start <= 1'b1;
                        r_state      <= StPushHi;
                    end
                end
                StPushHi: begin
                    if (w_push_done) begin
                        r_state <= StIdle;
                    end
                end
                StPushRd: begin
                    if (w_push_done) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    sys_ctrl_tx_push #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx_push (
        .CLK            (CLK),
        .RST            (RST),
        .i_start        (r_push_start),
        .i_byte         (r_push_byte),
        .i_fifo_full    (bus.fifo_full),
        .o_fifo_wr_inc  (w_fifo_wr_inc),
        .o_fifo_wr_data (w_fifo_wr_data),
        .o_done         (w_push_done)
    );

    assign bus.rf_addr      = r_addr;
    assign bus.rf_wr_en     = r_wr_en;
    assign bus.rf_rd_en     = r_rd_en;
    assign bus.rf_wr_data   = r_wr_data;
    assign bus.alu_en       = r_alu_en;
    assign bus.alu_fun      = r_alu_fun;
    assign bus.alu_clk_en   = r_alu_clk_en;
    assign bus.fifo_wr_data = w_fifo_wr_data;
    assign bus.fifo_wr_inc  = w_fifo_wr_inc;
    assign bus.busy         = (r_state != StIdle);
    assign bus.cmd_err      = r_cmd_err;

endmodule
